// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer that takes up
// to two instructions per cycle and presents the two oldest entries to decode.
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int EXC_W  = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       line1_pre_to_now_valid_i,
    input  logic                       line2_pre_to_now_valid_i,
    input  logic [PC_W-1:0]            pre_pc_i,
    input  logic [2*INST_W-1:0]        pre_inst_i,
    input  logic [EXC_W-1:0]           pre_excep_i,
    output logic                       now_allowin_o,
    input  logic                       flush_i,
    input  logic                       next_allowin_i,
    output logic                       line1_now_to_next_valid_o,
    output logic                       line2_now_to_next_valid_o,
    output logic [PC_W-1:0]            line1_pc_o,
    output logic [INST_W-1:0]          line1_inst_o,
    output logic [EXC_W-1:0]           line1_excep_o,
    output logic [PC_W-1:0]            line2_pc_o,
    output logic [INST_W-1:0]          line2_inst_o,
    output logic [EXC_W-1:0]           line2_excep_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic [EXC_W-1:0]  excep;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [CW-1:0] cnt;
    logic          push1, push2;
    logic          v1, v2;
    logic [1:0]    push_n, pop_n;
    entry_t        head, second;

    // Fetch always delivers pairs, so admission needs room for two.
    assign now_allowin_o = (cnt <= CW'(DEPTH - 2));

    // An excepting lane 1 squashes lane 2; lane 2 alone is never taken.
    assign push1  = line1_pre_to_now_valid_i & now_allowin_o & ~flush_i;
    assign push2  = push1 & line2_pre_to_now_valid_i & ~pre_excep_i[EXC_W-1];
    assign push_n = {1'b0, push1} + {1'b0, push2};

    // Head and next entry, indices wrap naturally at AW bits.
    assign head   = mem[rptr];
    assign second = mem[rptr + AW'(1)];

    // An exception entry issues alone so decode sees it in lane 1.
    assign v1    = (cnt != '0) & ~flush_i;
    assign v2    = (cnt >= CW'(2)) & ~flush_i & ~head.excep[EXC_W-1];
    assign pop_n = next_allowin_i ? ({1'b0, v1} + {1'b0, v2}) : 2'd0;

    assign line1_now_to_next_valid_o = v1;
    assign line2_now_to_next_valid_o = v2;
    assign line1_pc_o    = head.pc;
    assign line1_inst_o  = head.inst;
    assign line1_excep_o = head.excep;
    assign line2_pc_o    = second.pc;
    assign line2_inst_o  = second.inst;
    assign line2_excep_o = second.excep;
    assign count_o       = cnt;

    // Pointer and occupancy update; flush discards same-cycle push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else if (flush_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            rptr <= rptr + AW'(pop_n);
            wptr <= wptr + AW'(push_n);
            cnt  <= cnt + CW'(push_n) - CW'(pop_n);
        end
    end

    // Entry storage; contents need no reset since valids gate them.
    always_ff @(posedge clk) begin
        if (push1)
            mem[wptr] <= '{pc: pre_pc_i, inst: pre_inst_i[INST_W-1:0], excep: pre_excep_i};
        if (push2)
            mem[wptr + AW'(1)] <= '{pc: pre_pc_i + PC_W'(4),
                                    inst: pre_inst_i[2*INST_W-1:INST_W],
                                    excep: '0};
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_inst_queue;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        l1v, l2v;
    logic [31:0] pre_pc;
    logic [63:0] pre_inst;
    logic [6:0]  pre_exc;
    logic        allowin;
    logic        flush, nxt;
    logic        v1, v2;
    logic [31:0] pc1, inst1, pc2, inst2;
    logic [6:0]  exc1, exc2;
    logic [3:0]  cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  exc;
    } ent_t;
    ent_t mq[$];

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .line1_pre_to_now_valid_i(l1v), .line2_pre_to_now_valid_i(l2v),
        .pre_pc_i(pre_pc), .pre_inst_i(pre_inst), .pre_excep_i(pre_exc),
        .now_allowin_o(allowin), .flush_i(flush), .next_allowin_i(nxt),
        .line1_now_to_next_valid_o(v1), .line2_now_to_next_valid_o(v2),
        .line1_pc_o(pc1), .line1_inst_o(inst1), .line1_excep_o(exc1),
        .line2_pc_o(pc2), .line2_inst_o(inst2), .line2_excep_o(exc2),
        .count_o(cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic a1, input logic a2, input logic [31:0] pc,
                         input logic [63:0] ins, input logic [6:0] ex,
                         input logic nx, input logic fl);
        l1v = a1; l2v = a2; pre_pc = pc; pre_inst = ins; pre_exc = ex;
        nxt = nx; flush = fl;
    endtask

    // Advance one clock edge and apply the same event to the reference queue.
    task automatic tick();
        int  sz, np;
        bit  room;
        @(posedge clk);
        sz   = mq.size();
        room = (DEPTH - sz) >= 2;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            np = 0;
            if (nxt) begin
                if (sz >= 1) np++;
                if (sz >= 2 && !mq[0].exc[6]) np++;
            end
            repeat (np) void'(mq.pop_front());
            if (l1v && room) begin
                mq.push_back('{pc: pre_pc, inst: pre_inst[31:0], exc: pre_exc});
                if (l2v && !pre_exc[6])
                    mq.push_back('{pc: pre_pc + 32'd4, inst: pre_inst[63:32], exc: 7'd0});
            end
        end
        #1;
    endtask

    task automatic clear_queue();
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #7;
        total++; if (cnt !== 4'd0)  begin bad++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
        total++; if (v1 !== 1'b0 || v2 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b want=00", v1, v2); end
        total++; if (allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%b want=1", allowin); end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        tick();
    endtask

    task automatic test_pair();
        drive(1, 1, 32'h1c00_0000, {32'h0280_0802, 32'h0280_0401}, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (v1 !== 1'b1 || v2 !== 1'b1) begin bad++; $display("FAIL pair_valid got=%b%b want=11", v1, v2); end
        total++; if (pc1 !== 32'h1c00_0000) begin bad++; $display("FAIL pair_pc1 got=%h want=1c000000", pc1); end
        total++; if (pc2 !== 32'h1c00_0004) begin bad++; $display("FAIL pair_pc2 got=%h want=1c000004", pc2); end
        total++; if (inst1 !== 32'h0280_0401 || inst2 !== 32'h0280_0802)
            begin bad++; $display("FAIL pair_inst got=%h/%h want=02800401/02800802", inst1, inst2); end
        total++; if (cnt !== 4'd2) begin bad++; $display("FAIL pair_cnt got=%0d want=2", cnt); end
        tick();
    endtask

    task automatic test_fill();
        clear_queue();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h1000 + 32'(i * 8), {32'(2 * i + 1), 32'(2 * i)}, 0, 0, 0);
            @(negedge clk);
            total++; if (cnt !== 4'(2 * i)) begin bad++; $display("FAIL fill_cnt%0d got=%0d want=%0d", i, cnt, 2 * i); end
            total++; if (allowin !== 1'b1) begin bad++; $display("FAIL fill_allow%0d got=%b want=1", i, allowin); end
            tick();
        end
        drive(1, 1, 32'h2000, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (cnt !== 4'd8) begin bad++; $display("FAIL full_cnt got=%0d want=8", cnt); end
        total++; if (allowin !== 1'b0) begin bad++; $display("FAIL full_allow got=%b want=0", allowin); end
        tick();
        total++; if (cnt !== 4'd8) begin bad++; $display("FAIL full_hold got=%0d want=8", cnt); end
        drive(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        total++; if (pc1 !== 32'h1000 || pc2 !== 32'h1004) begin bad++; $display("FAIL full_head got=%h/%h want=1000/1004", pc1, pc2); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (cnt !== 4'd6 || allowin !== 1'b1) begin bad++; $display("FAIL drain_cnt got=%0d/%b want=6/1", cnt, allowin); end
        // Seven entries: one slot free but still no admission.
        drive(1, 0, 32'h3000, 0, 0, 0, 0);
        tick();
        drive(1, 1, 32'h3100, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (cnt !== 4'd7 || allowin !== 1'b0) begin bad++; $display("FAIL seven_allow got=%0d/%b want=7/0", cnt, allowin); end
        tick();
        total++; if (cnt !== 4'd7) begin bad++; $display("FAIL seven_hold got=%0d want=7", cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        clear_queue();
        drive(1, 1, 32'h4000, 0, 0, 0, 0);
        tick();
        exp_pc = 32'h4000;
        for (int i = 1; i <= 20; i++) begin
            drive(1, 1, 32'h4000 + 32'(i * 8), 0, 0, 1, 0);
            @(negedge clk);
            total++; if (cnt !== 4'd2) begin bad++; $display("FAIL b2b_cnt%0d got=%0d want=2", i, cnt); end
            total++; if (v1 !== 1'b1 || v2 !== 1'b1 || pc1 !== exp_pc || pc2 !== exp_pc + 32'd4)
                begin bad++; $display("FAIL b2b_pc%0d got=%b%b %h/%h want=11 %h/%h", i, v1, v2, pc1, pc2, exp_pc, exp_pc + 32'd4); end
            exp_pc += 32'd8;
            tick();
        end
    endtask

    task automatic test_excep();
        clear_queue();
        drive(1, 1, 32'h5000, {32'hdead_beef, 32'h1111_2222}, 7'h45, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (cnt !== 4'd1) begin bad++; $display("FAIL exc_cnt got=%0d want=1", cnt); end
        total++; if (exc1 !== 7'h45 || pc1 !== 32'h5000) begin bad++; $display("FAIL exc_head got=%h/%h want=45/5000", exc1, pc1); end
        total++; if (v1 !== 1'b1 || v2 !== 1'b0) begin bad++; $display("FAIL exc_valid got=%b%b want=10", v1, v2); end
        // With a normal entry behind it the exception still issues alone.
        drive(1, 1, 32'h5100, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        total++; if (cnt !== 4'd3 || v2 !== 1'b0) begin bad++; $display("FAIL exc_alone got=%0d/%b want=3/0", cnt, v2); end
        tick();
        @(negedge clk);
        total++; if (cnt !== 4'd2 || pc1 !== 32'h5100) begin bad++; $display("FAIL exc_pop got=%0d/%h want=2/5100", cnt, pc1); end
    endtask

    task automatic test_flush();
        clear_queue();
        drive(1, 1, 32'h6000, 0, 0, 0, 0); tick();
        drive(1, 1, 32'h6008, 0, 0, 0, 0); tick();
        drive(1, 0, 32'h6010, 0, 0, 0, 0); tick();
        drive(1, 1, 32'h6018, 0, 0, 1, 1);
        @(negedge clk);
        total++; if (cnt !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d want=5", cnt); end
        total++; if (v1 !== 1'b0 || v2 !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b%b want=00", v1, v2); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (cnt !== 4'd0 || allowin !== 1'b1) begin bad++; $display("FAIL flush_post got=%0d/%b want=0/1", cnt, allowin); end
    endtask

    task automatic test_wrap();
        clear_queue();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'h7000 + 32'(i * 8), 0, 0, 0, 0); tick();
        end
        drive(1, 0, 32'h7018, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        repeat (4) tick();
        drive(1, 1, 32'h1c00_0100, {32'hcafe_0002, 32'hcafe_0001}, 0, 0, 0);
        @(negedge clk);
        total++; if (cnt !== 4'd0) begin bad++; $display("FAIL wrap_empty got=%0d want=0", cnt); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        total++; if (v2 !== 1'b1 || pc1 !== 32'h1c00_0100 || pc2 !== 32'h1c00_0104 || inst2 !== 32'hcafe_0002)
            begin bad++; $display("FAIL wrap_lane2 got=%b %h/%h %h want=1 1c000100/1c000104 cafe0002", v2, pc1, pc2, inst2); end
    endtask

    task automatic test_random();
        int sz;
        logic ev1, ev2;
        clear_queue();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  {$urandom(), 2'b00} & 32'hffff_fffc, {$urandom(), $urandom()},
                  ($urandom_range(0, 5) == 0) ? (7'h40 | 7'($urandom_range(0, 63))) : 7'd0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
            @(negedge clk);
            sz  = mq.size();
            ev1 = (sz >= 1) && !flush;
            ev2 = (sz >= 2) && !flush && !mq[0].exc[6];
            total++; if (cnt !== 4'(sz)) begin bad++; $display("FAIL rnd_cnt%0d got=%0d want=%0d", i, cnt, sz); end
            total++; if (allowin !== ((DEPTH - sz) >= 2)) begin bad++; $display("FAIL rnd_allow%0d got=%b want=%b", i, allowin, (DEPTH - sz) >= 2); end
            total++; if (v1 !== ev1 || v2 !== ev2) begin bad++; $display("FAIL rnd_valid%0d got=%b%b want=%b%b", i, v1, v2, ev1, ev2); end
            if (ev1) begin
                total++;
                if (pc1 !== mq[0].pc || inst1 !== mq[0].inst || exc1 !== mq[0].exc)
                    begin bad++; $display("FAIL rnd_l1_%0d got=%h %h %h want=%h %h %h", i, pc1, inst1, exc1, mq[0].pc, mq[0].inst, mq[0].exc); end
            end
            if (ev2) begin
                total++;
                if (pc2 !== mq[1].pc || inst2 !== mq[1].inst || exc2 !== mq[1].exc)
                    begin bad++; $display("FAIL rnd_l2_%0d got=%h %h %h want=%h %h %h", i, pc2, inst2, exc2, mq[1].pc, mq[1].inst, mq[1].exc); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        clear_queue();
        drive(1, 1, 32'h8000, 0, 0, 0, 0); tick();
        drive(1, 1, 32'h8008, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        total++; if (cnt !== 4'd4) begin bad++; $display("FAIL rmid_pre got=%0d want=4", cnt); end
        rst_n = 1'b0;
        #1;
        total++; if (cnt !== 4'd0 || v1 !== 1'b0 || allowin !== 1'b1)
            begin bad++; $display("FAIL rmid_clear got=%0d/%b/%b want=0/0/1", cnt, v1, allowin); end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_pair();
        test_fill();
        test_back_to_back();
        test_excep();
        test_flush();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
